// File: rtl/udp_app_tx_pkt_arb.sv
// rtl/udp_app_tx_pkt_arb.sv - packet-granular round-robin arbiter for the shared UDP TX header+data stream
module udp_app_tx_pkt_arb #(
   parameter int NUM_SRC   = 2,
   parameter int SRC_W     = $clog2(NUM_SRC),
   parameter int MAX_BEATS = 64,
   parameter int CNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_arb_hdr_val,
   output logic [NUM_SRC-1:0] arb_src_hdr_rdy,
   input  logic [NUM_SRC-1:0] src_arb_data_val,
   input  logic [NUM_SRC-1:0] src_arb_data_last,
   output logic [NUM_SRC-1:0] arb_src_data_rdy,
   output logic               arb_dst_hdr_val,
   input  logic               dst_arb_hdr_rdy,
   output logic               arb_dst_data_val,
   output logic               arb_dst_data_last,
   input  logic               dst_arb_data_rdy,
   output logic [SRC_W-1:0]   ctrl_datap_sel,
   output logic               ctrl_err_oversize,
   output logic [CNT_W-1:0]   ctrl_pkt_cnt
);

   // beat counter must be able to hold MAX_BEATS itself so saturation is exact
   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]   sel_q, sel_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic               err_q, err_d;

   logic               pick_found;
   logic [SRC_W-1:0]   pick_idx;
   logic [SRC_W-1:0]   cand;

   // round-robin search: first requesting source at rr_ptr, rr_ptr+1, ... wrapping
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = '0;
      // walk from farthest to nearest so the nearest requester is the last one written
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_SRC);
         if (src_arb_hdr_val[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // next-state and valid/ready steering; all handshake outputs are gated by state
   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      sel_d             = sel_q;
      beat_cnt_d        = beat_cnt_q;
      pkt_cnt_d         = pkt_cnt_q;
      err_d             = err_q;
      arb_src_hdr_rdy   = '0;
      arb_src_data_rdy  = '0;
      arb_dst_hdr_val   = 1'b0;
      arb_dst_data_val  = 1'b0;
      arb_dst_data_last = 1'b0;

      case (state_q)
         S_IDLE: begin
            // arbitration bubble: the winner is only registered here, accepted next cycle
            if (pick_found) begin
               sel_d   = pick_idx;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            arb_dst_hdr_val        = src_arb_hdr_val[sel_q];
            arb_src_hdr_rdy[sel_q] = dst_arb_hdr_rdy;
            if (src_arb_hdr_val[sel_q] && dst_arb_hdr_rdy) begin
               state_d    = S_DATA;
               beat_cnt_d = '0;
            end
         end
         S_DATA: begin
            arb_dst_data_val        = src_arb_data_val[sel_q];
            arb_dst_data_last       = src_arb_data_last[sel_q];
            arb_src_data_rdy[sel_q] = dst_arb_data_rdy;
            if (src_arb_data_val[sel_q] && dst_arb_data_rdy) begin
               if (beat_cnt_q != BEAT_W'(MAX_BEATS)) begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
               if (src_arb_data_last[sel_q]) begin
                  pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                  rr_ptr_d  = (int'(sel_q) == NUM_SRC - 1) ? '0 : sel_q + SRC_W'(1);
                  state_d   = S_IDLE;
               end else if (beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
                  // packet keeps flowing; only the sticky flag records the overrun
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and bookkeeping registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_q      <= err_d;
      end
   end

   assign ctrl_datap_sel    = sel_q;
   assign ctrl_err_oversize = err_q;
   assign ctrl_pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_udp_app_tx_pkt_arb.sv
// tb/tb_udp_app_tx_pkt_arb.sv - scoreboard bench for udp_app_tx_pkt_arb
module tb_udp_app_tx_pkt_arb;

   localparam int NS = 2;
   localparam int MB = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NS-1:0] hdr_val, hdr_rdy, dat_val, dat_last, dat_rdy;
   logic          dst_hdr_val, dst_hdr_rdy, dst_dat_val, dst_dat_last, dst_dat_rdy;
   logic [0:0]    sel;
   logic          err;
   logic [CW-1:0] pkt_cnt;

   always #5 clk = ~clk;

   udp_app_tx_pkt_arb #(
      .NUM_SRC(NS), .SRC_W(1), .MAX_BEATS(MB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .src_arb_hdr_val(hdr_val), .arb_src_hdr_rdy(hdr_rdy),
      .src_arb_data_val(dat_val), .src_arb_data_last(dat_last), .arb_src_data_rdy(dat_rdy),
      .arb_dst_hdr_val(dst_hdr_val), .dst_arb_hdr_rdy(dst_hdr_rdy),
      .arb_dst_data_val(dst_dat_val), .arb_dst_data_last(dst_dat_last), .dst_arb_data_rdy(dst_dat_rdy),
      .ctrl_datap_sel(sel), .ctrl_err_oversize(err), .ctrl_pkt_cnt(pkt_cnt)
   );

   typedef struct {
      bit is_hdr;
      int src;
      bit last;
      bit exp_err;
      int pkt;
      int cyc;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   plen [NS][32];
   int   pwr [NS];
   int   prd [NS];
   int   st [NS];
   int   left [NS];
   bit   hs_h [NS];
   bit   hs_d [NS];
   bit   tog = 0;
   bit   m_err = 0;
   int   m_pkt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // queue one packet on a source and its expected downstream transfers
   task automatic push_pkt(input int s, input int n, input int c0);
      exp_t e;
      e.is_hdr = 1; e.src = s; e.last = 0; e.exp_err = m_err; e.pkt = m_pkt; e.cyc = c0;
      expq.push_back(e);
      for (int i = 1; i <= n; i++) begin
         e.is_hdr = 0; e.last = (i == n); e.exp_err = m_err;
         e.cyc = (c0 < 0) ? -1 : c0 + i;
         expq.push_back(e);
         if (i == MB && i != n) m_err = 1;
      end
      m_pkt = (m_pkt + 1) % 16;
      plen[s][pwr[s]] = n;
      pwr[s]++;
   endtask

   // sample handshakes and check the downstream side away from the active edge
   always @(negedge clk) begin
      exp_t e;
      for (int s = 0; s < NS; s++) begin
         hs_h[s] = hdr_val[s] & hdr_rdy[s];
         hs_d[s] = dat_val[s] & dat_rdy[s];
      end
      if (rst) begin
         if (expq.size() > 0 && !expq[0].is_hdr) begin
            chk("steer_sel", sel, expq[0].src);
            chk("steer_data_rdy", dat_rdy, dst_dat_rdy ? (1 << expq[0].src) : 0);
            chk("steer_data_val", dst_dat_val, dat_val[expq[0].src]);
            chk("steer_hdr_rdy", hdr_rdy, 0);
         end
         if (dst_hdr_val && dst_hdr_rdy) begin
            if (expq.size() == 0) chk("unexpected_hdr", 1, 0);
            else begin
               e = expq.pop_front();
               chk("hdr_order", 1, e.is_hdr);
               chk("hdr_sel", sel, e.src);
               chk("hdr_src_rdy", hdr_rdy, 1 << e.src);
               chk("hdr_pkt_cnt", pkt_cnt, e.pkt);
               if (e.cyc >= 0) chk("hdr_cycle", cyc, e.cyc);
            end
         end
         if (dst_dat_val && dst_dat_rdy) begin
            if (expq.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               e = expq.pop_front();
               chk("beat_order", 0, e.is_hdr);
               chk("beat_sel", sel, e.src);
               chk("beat_last", dst_dat_last, e.last);
               chk("beat_src_rdy", dat_rdy, 1 << e.src);
               chk("beat_oversize", err, e.exp_err);
               if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // source engines and formatter ready, driven just after the active edge
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         for (int s = 0; s < NS; s++) begin
            case (st[s])
               1: if (hs_h[s]) begin
                  hdr_val[s] = 0; dat_val[s] = 1; dat_last[s] = (left[s] == 1); st[s] = 2;
               end
               2: if (hs_d[s]) begin
                  left[s]--;
                  if (left[s] == 0) begin
                     dat_val[s] = 0; dat_last[s] = 0; st[s] = 0;
                  end else dat_last[s] = (left[s] == 1);
               end
               default: ;
            endcase
            if (st[s] == 0 && prd[s] != pwr[s]) begin
               left[s] = plen[s][prd[s]]; prd[s]++; hdr_val[s] = 1; st[s] = 1;
            end
         end
         dst_hdr_rdy = 1;
         dst_dat_rdy = tog ? ~dst_dat_rdy : 1'b1;
      end
   end

   task automatic do_reset();
      rst = 0;
      hdr_val = '0; dat_val = '0; dat_last = '0;
      dst_hdr_rdy = 1; dst_dat_rdy = 1; tog = 0;
      expq.delete();
      m_err = 0; m_pkt = 0;
      for (int s = 0; s < NS; s++) begin
         st[s] = 0; pwr[s] = 0; prd[s] = 0; left[s] = 0; hs_h[s] = 0; hs_d[s] = 0;
      end
      repeat (2) @(negedge clk);
      rst = 1;
      #1;
      chk("rst_sel", sel, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_handshake_outs", {hdr_rdy, dat_rdy, dst_hdr_val, dst_dat_val}, 0);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((expq.size() != 0 || st[0] != 0 || st[1] != 0) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk({name, "_pending"}, expq.size() + st[0] + st[1], 0);
      chk({name, "_idle_outs"}, {hdr_rdy, dat_rdy, dst_hdr_val, dst_dat_val}, 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset holds outputs at zero even with every source requesting
      rst = 0;
      hdr_val = '1; dat_val = '1; dat_last = '1; dst_hdr_rdy = 1; dst_dat_rdy = 1;
      #12;
      chk("inrst_outs", {hdr_rdy, dat_rdy, dst_hdr_val, dst_dat_val, dst_dat_last}, 0);

      // 1: single packet, cycle-exact, then rr_ptr=1 favours src1
      do_reset();
      #1;
      push_pkt(0, 3, cyc + 2);
      drain("t1", 40);
      chk("t1_pkt_cnt", pkt_cnt, 1);
      @(negedge clk); #1;
      push_pkt(1, 1, -1);
      push_pkt(0, 1, -1);
      drain("t1_rr", 40);
      chk("t1_rr_pkt_cnt", pkt_cnt, 3);

      // 2: both sources continuously requesting, alternating grants
      do_reset();
      #1;
      push_pkt(0, 2, -1); push_pkt(1, 2, -1);
      push_pkt(0, 2, -1); push_pkt(1, 2, -1);
      drain("t2", 80);
      chk("t2_pkt_cnt", pkt_cnt, 4);

      // 3: formatter data ready toggling every cycle
      do_reset();
      #1;
      tog = 1;
      push_pkt(1, 3, -1);
      drain("t3", 60);
      tog = 0;
      chk("t3_pkt_cnt", pkt_cnt, 1);

      // 4: six beats against MAX_BEATS=4
      do_reset();
      #1;
      push_pkt(0, 6, -1);
      drain("t4", 60);
      chk("t4_err_sticky", err, 1);
      chk("t4_pkt_cnt", pkt_cnt, 1);

      // 5: asynchronous reset after the second beat of a src1 packet
      @(negedge clk); #1;
      push_pkt(1, 4, -1);
      n = 0;
      while (expq.size() > 2 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      chk("t5_reach_beat2", expq.size(), 2);
      @(posedge clk); #3;
      rst = 0;
      #1;
      chk("t5_async_outs", {hdr_rdy, dat_rdy, dst_hdr_val, dst_dat_val}, 0);
      chk("t5_async_pkt_cnt", pkt_cnt, 0);
      chk("t5_async_sel", sel, 0);
      chk("t5_async_err", err, 0);
      do_reset();
      #1;
      push_pkt(0, 1, -1);
      push_pkt(1, 1, -1);
      drain("t5_rr", 40);

      // 6: 17 single-beat packets, 3 cycles each, counter wraps
      do_reset();
      #1;
      n = cyc + 2;
      for (int i = 0; i < 17; i++) push_pkt(0, 1, n + 3 * i);
      drain("t6", 120);
      chk("t6_wrap", pkt_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
